// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: states, opcodes, mux codes
// and the per-state control word decode used by multicycle_main_ctrl.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BEQ    = 4'd11,
    S_BNE    = 4'd12,
    S_JUMP   = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASS  = 3'b100;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_BTGT = 2'b01;
  localparam logic [1:0] PCSRC_JTGT = 2'b10;

  // pc_en is only partly a function of state; the rest comes from live inputs
  typedef enum logic [2:0] {
    PCC_NONE   = 3'd0,
    PCC_MEMRDY = 3'd1,
    PCC_ZERO   = 3'd2,
    PCC_NZERO  = 3'd3,
    PCC_ALWAYS = 3'd4
  } pc_cond_t;

  typedef struct packed {
    pc_cond_t   pc_cond;
    logic       ir_write_rdy;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(state_t s, logic is_ori);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.pc_cond      = PCC_MEMRDY;
        c.ir_write_rdy = 1'b1;
        c.mem_read     = 1'b1;
        c.alu_src_b    = SRCB_FOUR;
        c.alu_op       = ALU_ADD;
        c.pc_src       = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_BOFS;
        c.alu_op    = ALU_ADD;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = is_ori ? ALU_OR : ALU_ADD;
        c.imm_zext  = is_ori;
      end
      S_IWB: c.reg_write = 1'b1;
      S_BEQ, S_BNE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PCSRC_BTGT;
        c.pc_cond   = (s == S_BEQ) ? PCC_ZERO : PCC_NZERO;
      end
      S_JUMP: begin
        c.pc_src  = PCSRC_JTGT;
        c.pc_cond = PCC_ALWAYS;
      end
      S_TRAP: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_perf_cnt.sv
// Free-running cycle counter and retired-instruction counter; an instruction retires
// when FETCH is entered from any state other than IDLE, FETCH or TRAP.
module mc_ctrl_perf_cnt
  import mc_ctrl_pkg::*;
#(
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  state_t          state,
  input  state_t          state_nxt,
  output logic [CNTW-1:0] cycle_count,
  output logic [CNTW-1:0] instr_retired
);

  logic retire;

  assign retire = (state_nxt == S_FETCH) &&
                  !(state inside {S_IDLE, S_FETCH, S_TRAP});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= '0;
      instr_retired <= '0;
    end else begin
      cycle_count <= cycle_count + 1'b1;
      if (retire) instr_retired <= instr_retired + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_main_ctrl.sv
// Multicycle MIPS main control FSM with memory handshake, branch resolution and trap.
// Optional perf counters (cycle_count, instr_retired) exist when MC_CTRL_PERF_CNT_EN is defined.
module multicycle_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int ALUOPW      = 3,
  parameter int CNTW        = 32,
  parameter bit TRAP_STICKY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic [1:0]        pc_src,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic              imm_zext,
  output logic [ALUOPW-1:0] alu_op,
  output logic              illegal,
  output logic [3:0]        state_o
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [CNTW-1:0]   cycle_count,
  output logic [CNTW-1:0]   instr_retired
`endif
);

  if (OPW < 6 || ALUOPW < 3 || CNTW < 1) begin : g_param_check
    $error("multicycle_main_ctrl: OPW>=6, ALUOPW>=3, CNTW>=1 required");
  end

  state_t state, state_nxt;
  ctrl_t  ctrl_q;

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OPW'(OP_RTYPE):          state_nxt = S_EXEC;
          OPW'(OP_LW), OPW'(OP_SW): state_nxt = S_MEMADR;
          OPW'(OP_ADDI), OPW'(OP_ORI): state_nxt = S_IEXEC;
          OPW'(OP_BEQ):            state_nxt = S_BEQ;
          OPW'(OP_BNE):            state_nxt = S_BNE;
          OPW'(OP_J):              state_nxt = S_JUMP;
          default:                 state_nxt = S_TRAP;
        endcase
      end
      S_EXEC:   state_nxt = S_ALUWB;
      // only lw and sw reach MEMADR, so anything other than lw is a store
      S_MEMADR: state_nxt = (opcode == OPW'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_IEXEC:  state_nxt = S_IWB;
      S_ALUWB, S_MEMWB, S_IWB, S_BEQ, S_BNE, S_JUMP: state_nxt = S_FETCH;
      S_TRAP:   state_nxt = TRAP_STICKY ? S_TRAP : S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control word is registered alongside the state so outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ctrl_q <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= state_ctrl(state_nxt, opcode == OPW'(OP_ORI));
    end
  end

  always_comb begin
    pc_en = 1'b0;
    case (ctrl_q.pc_cond)
      PCC_MEMRDY: pc_en = mem_ready;
      PCC_ZERO:   pc_en = zero;
      PCC_NZERO:  pc_en = ~zero;
      PCC_ALWAYS: pc_en = 1'b1;
      default:    pc_en = 1'b0;
    endcase
  end

  assign ir_write   = ctrl_q.ir_write_rdy & mem_ready;
  assign pc_src     = ctrl_q.pc_src;
  assign iord       = ctrl_q.iord;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_write  = ctrl_q.reg_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign imm_zext   = ctrl_q.imm_zext;
  assign alu_op     = ALUOPW'(ctrl_q.alu_op);
  assign illegal    = ctrl_q.illegal;
  assign state_o    = state;

`ifdef MC_CTRL_PERF_CNT_EN
  mc_ctrl_perf_cnt #(
    .CNTW(CNTW)
  ) u_perf_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .state         (state),
    .state_nxt     (state_nxt),
    .cycle_count   (cycle_count),
    .instr_retired (instr_retired)
  );
`endif

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Scoreboard bench: instruction-level model queues expected control vectors per cycle,
// a monitor compares them against the DUT half a cycle after each rising edge.
module tb_multicycle_main_ctrl;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;

  logic pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
  logic alu_src_a, imm_zext, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state_o;

  logic pc_en_0, iord_0, mem_read_0, mem_write_0, ir_write_0, reg_write_0, reg_dst_0;
  logic mem_to_reg_0, alu_src_a_0, imm_zext_0, illegal_0;
  logic [1:0] pc_src_0, alu_src_b_0;
  logic [2:0] alu_op_0;
  logic [3:0] state_o_0;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [3:0] cycle_count, instr_retired, cycle_count_0, instr_retired_0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, a;
    logic [1:0] b;
    logic       zext;
    logic [2:0] aluop;
    logic       illegal;
  } vec_t;

  vec_t act;
  assign act = {state_o, pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_op, illegal};

  multicycle_main_ctrl #(.OPW(6), .ALUOPW(3), .CNTW(4), .TRAP_STICKY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_op(alu_op),
    .illegal(illegal), .state_o(state_o)
`ifdef MC_CTRL_PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_retired(instr_retired)
`endif
  );

  multicycle_main_ctrl #(.OPW(6), .ALUOPW(3), .CNTW(4), .TRAP_STICKY(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en_0), .pc_src(pc_src_0), .iord(iord_0), .mem_read(mem_read_0),
    .mem_write(mem_write_0), .ir_write(ir_write_0), .reg_write(reg_write_0),
    .reg_dst(reg_dst_0), .mem_to_reg(mem_to_reg_0), .alu_src_a(alu_src_a_0),
    .alu_src_b(alu_src_b_0), .imm_zext(imm_zext_0), .alu_op(alu_op_0),
    .illegal(illegal_0), .state_o(state_o_0)
`ifdef MC_CTRL_PERF_CNT_EN
    , .cycle_count(cycle_count_0), .instr_retired(instr_retired_0)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  vec_t  exp_q[$];
  string name_q[$];

  task automatic chk(string name, logic [63:0] a, logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, a, e, $time);
    end
  endtask

  // Expected control word for one cycle of a given micro-step, straight from the ISA rules
  function automatic vec_t expect_vec(state_t s, logic mr, logic z, logic [5:0] op);
    vec_t v;
    v = '0;
    v.st = s;
    case (s)
      S_FETCH:  begin v.mem_read = 1; v.b = 2'b01; v.pc_en = mr; v.ir_write = mr; end
      S_DECODE: v.b = 2'b11;
      S_EXEC:   begin v.a = 1; v.aluop = 3'b010; end
      S_ALUWB:  begin v.reg_write = 1; v.reg_dst = 1; end
      S_MEMADR: begin v.a = 1; v.b = 2'b10; end
      S_MEMRD:  begin v.mem_read = 1; v.iord = 1; end
      S_MEMWB:  begin v.reg_write = 1; v.mem_to_reg = 1; end
      S_MEMWR:  begin v.mem_write = 1; v.iord = 1; end
      S_IEXEC:  begin
        v.a = 1; v.b = 2'b10;
        if (op == 6'h0D) begin v.aluop = 3'b011; v.zext = 1; end
      end
      S_IWB:    v.reg_write = 1;
      S_BEQ:    begin v.a = 1; v.aluop = 3'b001; v.pc_src = 2'b01; v.pc_en = z; end
      S_BNE:    begin v.a = 1; v.aluop = 3'b001; v.pc_src = 2'b01; v.pc_en = ~z; end
      S_JUMP:   begin v.pc_src = 2'b10; v.pc_en = 1; end
      S_TRAP:   v.illegal = 1;
      default:  ;
    endcase
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(state_t s, logic mr, logic z);
    @(negedge clk);
    mem_ready = mr;
    zero = z;
    exp_q.push_back(expect_vec(s, mr, z, opcode));
    name_q.push_back(s.name());
  endtask

  // One complete instruction: fetch waits fw, memory waits mw, branch flag zf
  task automatic run_instr(logic [5:0] op, int fw, int mw, logic zf);
    opcode = op;
    repeat (fw) cyc(S_FETCH, 1'b0, rb());
    cyc(S_FETCH, 1'b1, rb());
    cyc(S_DECODE, rb(), rb());
    case (op)
      6'h00: begin cyc(S_EXEC, rb(), rb()); cyc(S_ALUWB, rb(), rb()); end
      6'h23: begin
        cyc(S_MEMADR, rb(), rb());
        repeat (mw) cyc(S_MEMRD, 1'b0, rb());
        cyc(S_MEMRD, 1'b1, rb());
        cyc(S_MEMWB, rb(), rb());
      end
      6'h2B: begin
        cyc(S_MEMADR, rb(), rb());
        repeat (mw) cyc(S_MEMWR, 1'b0, rb());
        cyc(S_MEMWR, 1'b1, rb());
      end
      6'h08, 6'h0D: begin cyc(S_IEXEC, rb(), rb()); cyc(S_IWB, rb(), rb()); end
      6'h04: cyc(S_BEQ, rb(), zf);
      6'h05: cyc(S_BNE, rb(), zf);
      6'h02: cyc(S_JUMP, rb(), rb());
      default: begin
        for (int i = 0; i < 12; i++) begin
          cyc(S_TRAP, rb(), rb());
          #2;
          if (i == 0) chk("nonsticky_trap", {illegal_0, state_o_0}, {1'b1, S_TRAP});
          if (i == 1) chk("nonsticky_exit", {illegal_0, state_o_0}, {1'b0, S_FETCH});
        end
      end
    endcase
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_mem_write", 64'(mem_write), 64'd0);
    chk("rst_async_state", 64'(state_o), 64'(S_IDLE));
    cyc(S_IDLE, rb(), rb());
    cyc(S_IDLE, rb(), rb());
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    vec_t e;
    string n;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk(n, 64'(act), 64'(e));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0D, 6'h04, 6'h05, 6'h02};

    do_reset();
    run_instr(6'h23, 2, 2, 1'b0);
    run_instr(6'h04, 0, 0, 1'b1);
    run_instr(6'h04, 1, 0, 1'b0);
    run_instr(6'h05, 0, 0, 1'b1);
    run_instr(6'h05, 0, 0, 1'b0);
    run_instr(6'h0D, 0, 0, 1'b0);
    run_instr(6'h08, 1, 0, 1'b0);
    run_instr(6'h2B, 0, 3, 1'b0);

    for (int k = 0; k < 80; k++)
      run_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3), rb());

    // reset lands while a store is stalled with mem_write asserted
    opcode = 6'h2B;
    cyc(S_FETCH, 1'b1, 1'b0);
    cyc(S_DECODE, 1'b0, 1'b0);
    cyc(S_MEMADR, 1'b0, 1'b0);
    cyc(S_MEMWR, 1'b0, 1'b0);
    do_reset();
    run_instr(6'h00, 1, 0, 1'b0);

    do_reset();
    run_instr(6'h3F, 1, 0, 1'b0);
    do_reset();
    run_instr(6'h02, 0, 0, 1'b0);

`ifdef MC_CTRL_PERF_CNT_EN
    do_reset();
    repeat (17) run_instr(6'h00, $urandom_range(0, 2), 0, 1'b0);
    cyc(S_FETCH, 1'b0, 1'b0);
    #2 chk("instr_retired_wrap", 64'(instr_retired), 64'd1);
`endif

    repeat (2) @(negedge clk);
    #3;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
